// File: rtl/seg7_pkg.sv
// Shared state encoding and segment patterns for the 7-segment scan driver.
package seg7_pkg;

    // Raw state encodings, kept as plain constants for legacy consumers.
    localparam logic [1:0] ST_OFF   = 2'd0;
    localparam logic [1:0] ST_GHOST = 2'd1;
    localparam logic [1:0] ST_DRIVE = 2'd2;

    typedef enum logic [1:0] {
        OFF   = ST_OFF,
        GHOST = ST_GHOST,
        DRIVE = ST_DRIVE
    } state_e;

    // Active-low {g,f,e,d,c,b,a} patterns.
    localparam logic [6:0] SEG_BLANK = 7'h7F;
    localparam logic [6:0] SEG_DASH  = 7'h3F;

    // Nibble -> segment pattern; non-decimal nibbles show a dash.
    localparam logic [6:0] SEG_LUT [0:15] = '{
        7'h40, 7'h79, 7'h24, 7'h30, 7'h19, 7'h12, 7'h02, 7'h78,
        7'h00, 7'h10, SEG_DASH, SEG_DASH, SEG_DASH, SEG_DASH, SEG_DASH, SEG_DASH
    };

endpackage

// File: rtl/seg7_decode.sv
// Combinational BCD nibble to active-low segment pattern.
module seg7_decode
    import seg7_pkg::*;
(
    input  logic [3:0] nib,
    output logic [6:0] seg_c
);

    // Table lookup on the selected nibble.
    always_comb begin
        seg_c = SEG_LUT[nib];
    end

endmodule

// File: rtl/seg7_scan_driver.sv
// Captures a packed BCD word on the BCD-stage done edge and time-multiplexes
// it onto a common-anode display with blanking dead time, leading-zero
// suppression and a fixed decimal point.
module seg7_scan_driver
    import seg7_pkg::*;
#(
    parameter int NUM_DIGITS   = 4,
    parameter int AN_WIDTH     = 8,
    parameter int DIGIT_PERIOD = 100000,
    parameter int GHOST_CYCLES = 16,
    parameter int DP_POS       = 2
) (
    input  logic                    clk,
    input  logic                    rst,
    input  logic [4*NUM_DIGITS-1:0] dec_in,
    input  logic                    data_from_bcd_trcvd,
    output logic [AN_WIDTH-1:0]     an,
    output logic [6:0]              seg,
    output logic                    dp,
    output logic                    disp_ack
);

    localparam int unsigned DW    = 4 * NUM_DIGITS;
    localparam int unsigned IDX_W = (NUM_DIGITS > 1) ? $clog2(NUM_DIGITS) : 1;
    localparam int unsigned CNT_W = (DIGIT_PERIOD > 1) ? $clog2(DIGIT_PERIOD) : 1;

    state_e                state_q, state_d;
    logic [CNT_W-1:0]      cnt_q, cnt_d;
    logic [IDX_W-1:0]      idx_q, idx_d;
    logic [DW-1:0]         shadow_q, shadow_d;
    logic                  valid_q, valid_d;
    logic                  hist_q, hist_d;
    logic                  ack_q, ack_d;
    logic [AN_WIDTH-1:0]   an_q, an_d;
    logic [6:0]            seg_q, seg_d;
    logic                  dp_q, dp_d;

    logic                  capture_c;
    logic [NUM_DIGITS-1:0] blank_c;
    logic                  zero_run_c;
    logic [3:0]            cur_nib_c;
    logic                  cur_blank_c;
    logic                  cur_dp_c;
    logic [6:0]            dec_seg_c;

    assign capture_c = data_from_bcd_trcvd & ~hist_q;

    // Leading-zero map: digit k blanks when it and every higher digit are zero.
    always_comb begin
        zero_run_c = 1'b1;
        blank_c    = '0;
        for (int k = NUM_DIGITS - 1; k >= 0; k--) begin
            zero_run_c = zero_run_c && (shadow_q[4*k +: 4] == 4'd0);
            blank_c[k] = zero_run_c && (k > DP_POS) && (k > 0);
        end
    end

    // Select nibble, blank flag and dp flag for the current slot.
    always_comb begin
        cur_nib_c   = 4'd0;
        cur_blank_c = 1'b0;
        cur_dp_c    = 1'b0;
        for (int k = 0; k < NUM_DIGITS; k++) begin
            if (idx_q == IDX_W'(k)) begin
                cur_nib_c   = shadow_q[4*k +: 4];
                cur_blank_c = blank_c[k];
                cur_dp_c    = (k == DP_POS);
            end
        end
    end

    seg7_decode u_decode (
        .nib   (cur_nib_c),
        .seg_c (dec_seg_c)
    );

    // Next-state, capture and registered-output computation.
    always_comb begin
        state_d  = state_q;
        cnt_d    = cnt_q;
        idx_d    = idx_q;
        shadow_d = shadow_q;
        valid_d  = valid_q;
        hist_d   = data_from_bcd_trcvd;
        ack_d    = capture_c;
        an_d     = '1;
        seg_d    = SEG_BLANK;
        dp_d     = 1'b1;

        if (capture_c) begin
            shadow_d = dec_in;
            valid_d  = 1'b1;
        end

        unique case (state_q)
            OFF: begin
                cnt_d = '0;
                idx_d = '0;
                if (capture_c) begin
                    state_d = GHOST;
                end
            end
            GHOST: begin
                cnt_d = cnt_q + CNT_W'(1);
                if (cnt_q == CNT_W'(GHOST_CYCLES - 1)) begin
                    state_d = DRIVE;
                end
            end
            DRIVE: begin
                if (valid_q && !cur_blank_c) begin
                    for (int k = 0; k < NUM_DIGITS; k++) begin
                        if (idx_q == IDX_W'(k)) begin
                            an_d[k] = 1'b0;
                        end
                    end
                    seg_d = dec_seg_c;
                    dp_d  = ~cur_dp_c;
                end
                if (cnt_q == CNT_W'(DIGIT_PERIOD - 1)) begin
                    cnt_d   = '0;
                    state_d = GHOST;
                    idx_d   = (idx_q == IDX_W'(NUM_DIGITS - 1)) ? '0 : idx_q + IDX_W'(1);
                end else begin
                    cnt_d = cnt_q + CNT_W'(1);
                end
            end
            default: begin
                state_d = OFF;
                cnt_d   = '0;
                idx_d   = '0;
            end
        endcase
    end

    // State and output registers; reset blanks the pins immediately.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q  <= OFF;
            cnt_q    <= '0;
            idx_q    <= '0;
            shadow_q <= '0;
            valid_q  <= 1'b0;
            hist_q   <= 1'b0;
            ack_q    <= 1'b0;
            an_q     <= '1;
            seg_q    <= SEG_BLANK;
            dp_q     <= 1'b1;
        end else begin
            state_q  <= state_d;
            cnt_q    <= cnt_d;
            idx_q    <= idx_d;
            shadow_q <= shadow_d;
            valid_q  <= valid_d;
            hist_q   <= hist_d;
            ack_q    <= ack_d;
            an_q     <= an_d;
            seg_q    <= seg_d;
            dp_q     <= dp_d;
        end
    end

    assign an       = an_q;
    assign seg      = seg_q;
    assign dp       = dp_q;
    assign disp_ack = ack_q;

endmodule

// File: tb/tb_seg7_scan_driver.sv
// Scoreboard bench for seg7_scan_driver with an 8-cycle slot and 2-cycle dead time.
module tb_seg7_scan_driver;

    logic        clk;
    logic        rst;
    logic [15:0] dec_in;
    logic        data_from_bcd_trcvd;
    logic [7:0]  an;
    logic [6:0]  seg;
    logic        dp;
    logic        disp_ack;

    int cyc;
    int checks;
    int failures;

    typedef struct {
        int         cyc;
        logic [7:0] an;
        logic [6:0] seg;
        logic       dp;
        logic       ack;
    } exp_t;

    exp_t sb[$];

    // Per-digit expectations for the word currently being pushed.
    logic [7:0] t_an  [4];
    logic [6:0] t_seg [4];
    logic       t_dp  [4];

    // Cycles in which disp_ack must be high.
    int ack_cyc [6] = '{111, 143, 175, 207, 239, 281};

    seg7_scan_driver #(
        .NUM_DIGITS   (4),
        .AN_WIDTH     (8),
        .DIGIT_PERIOD (8),
        .GHOST_CYCLES (2),
        .DP_POS       (2)
    ) dut (
        .clk                 (clk),
        .rst                 (rst),
        .dec_in              (dec_in),
        .data_from_bcd_trcvd (data_from_bcd_trcvd),
        .an                  (an),
        .seg                 (seg),
        .dp                  (dp),
        .disp_ack            (disp_ack)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    always @(posedge clk) cyc <= cyc + 1;

    function automatic logic is_ack(input int c);
        foreach (ack_cyc[i]) begin
            if (ack_cyc[i] == c) return 1'b1;
        end
        return 1'b0;
    endfunction

    // Digits 0..2 always shown; digit 3 optionally leading-zero blanked.
    task automatic set_digits(input logic [6:0] s0, input logic [6:0] s1,
                              input logic [6:0] s2, input logic [6:0] s3,
                              input logic b3);
        t_an[0] = 8'hFE; t_seg[0] = s0; t_dp[0] = 1'b1;
        t_an[1] = 8'hFD; t_seg[1] = s1; t_dp[1] = 1'b1;
        t_an[2] = 8'hFB; t_seg[2] = s2; t_dp[2] = 1'b0;
        t_an[3] = b3 ? 8'hFF : 8'hF7;
        t_seg[3] = b3 ? 7'h7F : s3;
        t_dp[3] = 1'b1;
    endtask

    // Queue expected pins for cycles from_c..to_c; slots start at base.
    task automatic push_range(input int from_c, input int to_c, input int base,
                              input logic blank_all);
        exp_t e;
        int   ph;
        int   d;
        for (int c = from_c; c <= to_c; c++) begin
            e.cyc = c;
            e.ack = is_ack(c);
            e.an  = 8'hFF;
            e.seg = 7'h7F;
            e.dp  = 1'b1;
            if (!blank_all) begin
                ph = (c - base) % 8;
                d  = ((c - base) / 8) % 4;
                if (ph >= 2) begin
                    e.an  = t_an[d];
                    e.seg = t_seg[d];
                    e.dp  = t_dp[d];
                end
            end
            sb.push_back(e);
        end
    endtask

    task automatic chk(input string name, input int c, input logic [7:0] act,
                       input logic [7:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s cyc=%0d actual=%h expected=%h", name, c, act, exp);
        end
    endtask

    task automatic wait_cyc(input int n);
        while (cyc < n) begin
            @(posedge clk);
            #1;
        end
    endtask

    // Monitor: compare pins against the queued expectation for this cycle.
    always @(negedge clk) begin
        exp_t e;
        if (sb.size() > 0 && sb[0].cyc <= cyc) begin
            e = sb.pop_front();
            if (e.cyc < cyc) begin
                checks++;
                failures++;
                $display("FAIL stale_expect cyc=%0d actual_cyc=%0d", e.cyc, cyc);
            end else begin
                chk("disp_ack", cyc, {7'd0, disp_ack}, {7'd0, e.ack});
                chk("an", cyc, an, e.an);
                chk("seg", cyc, {1'b0, seg}, {1'b0, e.seg});
                chk("dp", cyc, {7'd0, dp}, {7'd0, e.dp});
            end
        end
    end

    // Stimulus: expectations are queued up front, then the vectors are driven.
    initial begin
        cyc                 = 0;
        checks              = 0;
        failures            = 0;
        rst                 = 1'b1;
        dec_in              = 16'h0000;
        data_from_bcd_trcvd = 1'b0;

        push_range(1, 111, 0, 1'b1);
        set_digits(7'h19, 7'h30, 7'h24, 7'h79, 1'b0);
        push_range(112, 143, 112, 1'b0);
        set_digits(7'h12, 7'h40, 7'h40, 7'h7F, 1'b1);
        push_range(144, 175, 112, 1'b0);
        set_digits(7'h19, 7'h3F, 7'h24, 7'h79, 1'b0);
        push_range(176, 207, 112, 1'b0);
        set_digits(7'h24, 7'h19, 7'h40, 7'h7F, 1'b1);
        push_range(208, 239, 112, 1'b0);
        set_digits(7'h10, 7'h10, 7'h40, 7'h7F, 1'b1);
        push_range(240, 259, 112, 1'b0);
        push_range(260, 281, 0, 1'b1);
        set_digits(7'h19, 7'h30, 7'h24, 7'h79, 1'b0);
        push_range(282, 313, 282, 1'b0);

        wait_cyc(3);
        rst = 1'b0;

        // 1234, single-cycle strobe
        wait_cyc(110);
        dec_in = 16'h1234;
        data_from_bcd_trcvd = 1'b1;
        wait_cyc(111);
        data_from_bcd_trcvd = 1'b0;

        // 0005: leading-zero blanking of digit 3
        wait_cyc(142);
        dec_in = 16'h0005;
        data_from_bcd_trcvd = 1'b1;
        wait_cyc(143);
        data_from_bcd_trcvd = 1'b0;

        // 12A4: dash on digit 1
        wait_cyc(174);
        dec_in = 16'h12A4;
        data_from_bcd_trcvd = 1'b1;
        wait_cyc(175);
        data_from_bcd_trcvd = 1'b0;

        // Held strobe: one capture, later data ignored until a fresh edge
        wait_cyc(206);
        dec_in = 16'h0042;
        data_from_bcd_trcvd = 1'b1;
        wait_cyc(211);
        dec_in = 16'h0099;
        wait_cyc(216);
        data_from_bcd_trcvd = 1'b0;
        wait_cyc(238);
        data_from_bcd_trcvd = 1'b1;
        wait_cyc(239);
        data_from_bcd_trcvd = 1'b0;

        // Reset mid-DRIVE of digit 2, then restart from digit 0
        wait_cyc(260);
        rst = 1'b1;
        wait_cyc(261);
        rst = 1'b0;
        wait_cyc(280);
        dec_in = 16'h1234;
        data_from_bcd_trcvd = 1'b1;
        wait_cyc(281);
        data_from_bcd_trcvd = 1'b0;

        wait_cyc(320);
        checks++;
        if (sb.size() != 0) begin
            failures++;
            $display("FAIL scoreboard_drain actual=%0d expected=0", sb.size());
        end

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule

// File: doc/seg7_scan_driver.md
Name: seg7_scan_driver

Overview:
- Downstream consumer of the binary-to-BCD stage.
- Captures the 4-digit packed BCD word on that stage's done strobe and time-multiplexes it onto the board's common-anode 7-segment display.
- Provides leading-zero blanking, a fixed decimal point, anti-ghosting dead time, and a one-cycle capture acknowledge.

Parameters:
- NUM_DIGITS, 4: BCD digits consumed; dec_in width is 4*NUM_DIGITS.
- AN_WIDTH, 8: physical anodes. Anodes at index NUM_DIGITS and above are always off.
- DIGIT_PERIOD, 100000: clk cycles per digit slot, 1 kHz at 100 MHz. Must be greater than GHOST_CYCLES.
- GHOST_CYCLES, 16: cycles at the start of each slot with all anodes off.
- DP_POS, 2: digit index whose decimal point is lit. Any value of NUM_DIGITS or above disables the dp.

Ports:
- clk  in  1  system clock
- rst  in  1  asynchronous, active-high reset
- dec_in  in  4*NUM_DIGITS  packed BCD; digit 0 is at [3:0]
- data_from_bcd_trcvd  in  1  done strobe from the BCD stage (may be held high for several cycles)
- an  out  AN_WIDTH  anode enables, active-low
- seg  out  7  segments {g,f,e,d,c,b,a}, active-low
- dp  out  1  decimal point, active-low
- disp_ack  out  1  one-cycle pulse, the cycle after a capture

Behaviour:
- Reset (async, active-high): an='1, seg=7'h7F, dp=1, disp_ack=0, shadow=0, valid=0, slot index=0, slot counter=0, strobe history=0, state=OFF. Outputs go inactive immediately, mid-slot included.
- Capture:
  - Strobe history is registered; a capture occurs on the cycle where data_from_bcd_trcvd=1 and history=0 (rising edge).
  - On capture: shadow<=dec_in, valid<=1, disp_ack=1 on the next cycle only.
  - A strobe held high produces exactly one capture.
- States:
  - OFF: entered from reset. Blanks the display, holds counters at 0. Goes to GHOST on the cycle after the first capture.
  - GHOST: an='1, seg=7'h7F, dp=1 for GHOST_CYCLES cycles, then DRIVE.
  - DRIVE: for the remaining DIGIT_PERIOD-GHOST_CYCLES cycles of the slot, drives the current digit, then returns to GHOST. The slot index increments mod NUM_DIGITS at that transition.
  - Slot counter runs 0..DIGIT_PERIOD-1 and wraps to 0; the index wraps NUM_DIGITS-1 -> 0.
- Drive decode:
  - an has bit[index]=0 and all other bits 1.
  - seg = decode(shadow nibble[index]): 0->40, 1->79, 2->24, 3->30, 4->19, 5->12, 6->02, 7->78, 8->00, 9->10 (hex).
  - Nibbles 10..15 display a dash, 7'h3F.
  - dp=0 only when index==DP_POS.
- Leading-zero blanking:
  - Digit k is blank (its anode stays high for the whole slot) when all nibbles k..NUM_DIGITS-1 are 0, k>DP_POS, and k>0.
  - Digit 0 and every digit at or below DP_POS always display.
- Timing:
  - All outputs are registered: one-cycle latency from state, index or shadow to pins.
  - A capture mid-DRIVE changes the displayed digit from the following cycle. No slot restart.
  - A capture coinciding with a slot boundary is applied to the new slot on its first DRIVE cycle.
  - Once valid=1, it is only cleared by rst.
- Reset asserted mid-operation clears everything. The display stays in OFF until a fresh strobe edge arrives, even if data_from_bcd_trcvd is high while rst deasserts. In that case history is 0, so an edge is seen on the first cycle after release.

Decomposition:
- Package seg7_pkg holds:
  - the state enum typedef {OFF, GHOST, DRIVE}
  - the segment constants SEG_BLANK=7'h7F and SEG_DASH=7'h3F
  - the 16-entry segment lookup constant array
- Sub-module seg7_decode: combinational, nibble -> 7-bit active-low pattern via the package table. Instantiated once on the muxed nibble.

Test Plan (DIGIT_PERIOD=8, GHOST_CYCLES=2, DP_POS=2, NUM_DIGITS=4):
1. Reset release, no strobe for 100 cycles -> an=8'hFF, seg=7'h7F, dp=1 and disp_ack=0 throughout.
2. dec_in=16'h1234, strobe 1 cycle -> disp_ack=1 exactly one cycle later. Then 2 blank cycles, then 6 cycles of an=8'hFE with seg=7'h19. Subsequent slots: 8'hFD/7'h30, then 8'hFB/7'h24 with dp=0, then 8'hF7/7'h79, then repeat.
3. dec_in=16'h0005 -> digit 3 anode high for its entire slot. Digit 2 shows 7'h40 with dp=0, digit 1 shows 7'h40, digit 0 shows 7'h12.
4. dec_in=16'h12A4 -> digit 1 slot shows 7'h3F. Other digits decode normally.
5. Strobe held high 10 cycles with dec_in=16'h0042, then dec_in changes to 16'h0099 while the strobe is still high -> single disp_ack. Display keeps 0042 until the strobe falls and rises again with 16'h0099.
6. rst pulsed for 1 cycle mid-DRIVE of digit 2 -> an=8'hFF and seg=7'h7F in the same cycle, without waiting for a clk edge. Display stays off until the next strobe edge, then restarts at digit 0.
